uart_rx_fsm: RTL and testbench

- Control FSM and edge/bit counter for the UART receive path.
- Detects the start bit on RX_IN and counts oversampling edges and data bits.
- Drives the enables of the sampler, start/parity/stop checkers and deserializer, and issues data_valid after a clean frame.
- Feeds edge_cnt and stp_chk_en to the stop-bit checker directly downstream and consumes its stp_err.

---
 rtl/uart_rx_fsm.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm
//
// Control FSM and oversampling edge/bit counter for the UART receive path.
// It detects the falling start edge on RX_IN, walks the frame through
// START -> DATA -> [PARITY] -> STOP -> ERR_CHK one oversampled bit at a time,
// enables the sampler and the start/parity/stop checkers for each phase,
// strobes the deserializer once per data bit, and pulses data_valid for
// exactly one cycle when a frame completes without stop or parity errors.
//
// Parameters
//   DATA_WIDTH   data bits per frame (bit_cnt runs 0..DATA_WIDTH-1)
//
// Ports
//   clk          receive clock, rising edge
//   ARST_n       asynchronous active-low reset
//   RX_IN        serial line, idle high, already synchronized
//   PAR_EN       1 = frame carries a parity bit (captured at DATA exit)
//   Prescale     oversampling ratio (8, 16 or 32), captured on start detect
//   strt_glitch  start checker result, valid late in START
//   par_err      parity checker result (registered)
//   stp_err      stop checker result (registered mid-STOP)
//   edge_cnt     oversampling edge index within the current bit
//   bit_cnt      data bit index within DATA
//   dat_samp_en  sampler enable
//   strt_chk_en  start checker enable
//   deser_en     deserializer shift strobe, one cycle per data bit
//   par_chk_en   parity checker enable
//   stp_chk_en   stop checker enable
//   data_valid   one-cycle frame-accepted pulse
//   busy         frame in progress
// -----------------------------------------------------------------------------
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       clk,
    input  logic       ARST_n,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] Prescale,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic [4:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       dat_samp_en,
    output logic       strt_chk_en,
    output logic       deser_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        ERR_CHK = 3'd5
    } state_t;

    localparam logic [3:0] BIT_LAST = 4'(DATA_WIDTH - 1);

    state_t     state;
    state_t     next_state;
    logic [5:0] presc_q;
    logic       par_en_frame;

    logic [4:0] last_edge;
    logic [4:0] mid_edge;
    logic       edge_last;
    logic       bit_last;
    logic       frame_start;
    logic       data_exit;

    // Bit timing is derived from the prescale captured for this frame.
    // Working modulo 32 makes a prescale of 32 give a last edge of 31,
    // while the midpoint uses the full value so 32 gives 17.
    assign last_edge   = presc_q[4:0] - 5'd1;
    assign mid_edge    = presc_q[5:1] + 5'd1;
    assign edge_last   = (edge_cnt == last_edge);
    assign bit_last    = (bit_cnt == BIT_LAST);

    // Any entry into START (from IDLE or a back-to-back ERR_CHK) restarts
    // the edge count at 1 because the detect cycle itself is edge 0.
    assign frame_start = (next_state == START) && (state != START);
    assign data_exit   = (state == DATA) && edge_last && bit_last;

    // State register.
    always_ff @(posedge clk or negedge ARST_n) begin
        if (!ARST_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. RX_IN only matters in IDLE and ERR_CHK; in every
    // other state the frame advances purely on the edge counter.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (!RX_IN) begin
                    next_state = START;
                end
            end
            START: begin
                if (edge_last) begin
                    next_state = strt_glitch ? IDLE : DATA;
                end
            end
            DATA: begin
                if (edge_last && bit_last) begin
                    next_state = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (edge_last) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (edge_last) begin
                    next_state = ERR_CHK;
                end
            end
            ERR_CHK: begin
                next_state = RX_IN ? IDLE : START;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode from the registered state. The stop checker result is
    // still valid in ERR_CHK because stp_chk_en only drops on entry to it.
    always_comb begin
        dat_samp_en = 1'b0;
        strt_chk_en = 1'b0;
        deser_en    = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        data_valid  = 1'b0;
        busy        = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
            end
            START: begin
                busy        = 1'b1;
                dat_samp_en = 1'b1;
                strt_chk_en = 1'b1;
            end
            DATA: begin
                busy        = 1'b1;
                dat_samp_en = 1'b1;
                deser_en    = (edge_cnt == mid_edge);
            end
            PARITY: begin
                busy        = 1'b1;
                dat_samp_en = 1'b1;
                par_chk_en  = 1'b1;
            end
            STOP: begin
                busy        = 1'b1;
                dat_samp_en = 1'b1;
                stp_chk_en  = 1'b1;
            end
            ERR_CHK: begin
                busy       = 1'b1;
                data_valid = ~stp_err & ~(par_en_frame & par_err);
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Oversampling edge counter: free-runs through the active bit states,
    // wrapping after the last edge of each bit, and sits at 0 otherwise.
    always_ff @(posedge clk or negedge ARST_n) begin
        if (!ARST_n) begin
            edge_cnt <= 5'd0;
        end else if (frame_start) begin
            edge_cnt <= 5'd1;
        end else begin
            unique case (state)
                START, DATA, PARITY, STOP: begin
                    edge_cnt <= edge_last ? 5'd0 : edge_cnt + 5'd1;
                end
                default: begin
                    edge_cnt <= 5'd0;
                end
            endcase
        end
    end

    // Data bit counter: advances at the end of each data bit and clears on
    // leaving DATA, so it never exceeds the last data bit index.
    always_ff @(posedge clk or negedge ARST_n) begin
        if (!ARST_n) begin
            bit_cnt <= 4'd0;
        end else if (state != DATA) begin
            bit_cnt <= 4'd0;
        end else if (edge_last) begin
            bit_cnt <= bit_last ? 4'd0 : bit_cnt + 4'd1;
        end
    end

    // Prescale is frozen on the start detect so that reprogramming it
    // mid-frame cannot disturb the bit timing of the frame in flight.
    always_ff @(posedge clk or negedge ARST_n) begin
        if (!ARST_n) begin
            presc_q <= 6'd8;
        end else if ((state == IDLE) && (next_state == START)) begin
            presc_q <= Prescale;
        end
    end

    // The parity enable seen when DATA finishes decides whether par_err is
    // allowed to veto data_valid for this frame.
    always_ff @(posedge clk or negedge ARST_n) begin
        if (!ARST_n) begin
            par_en_frame <= 1'b0;
        end else if (data_exit) begin
            par_en_frame <= PAR_EN;
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fsm
//
// Self-checking bench for uart_rx_fsm. A table of frame records (prescale,
// parity enable, data byte, injected checker errors, chaining and expected
// data_valid) is replayed cycle by cycle against an expected output vector
// computed from the cycle index within the frame. Start glitch and
// mid-frame reset are exercised by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_uart_rx_fsm;

    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       ARST_n;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] Prescale;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en;
    logic       strt_chk_en;
    logic       deser_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;
    logic       busy;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        string      name;
        int         presc;
        bit         par_en;
        logic [7:0] data;
        bit         par_err_f;
        bit         stp_err_f;
        int         chg_presc;
        bit         chain_in;
        bit         chain_out;
        bit         exp_valid;
    } frame_vec_t;

    frame_vec_t vecs [10];

    uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .ARST_n      (ARST_n),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .Prescale    (Prescale),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .dat_samp_en (dat_samp_en),
        .strt_chk_en (strt_chk_en),
        .deser_en    (deser_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .data_valid  (data_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // {edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en,
    //  stp_chk_en, data_valid, busy}
    function automatic logic [15:0] pack(input int e, input int b,
                                         input bit dat, input bit strt,
                                         input bit deser, input bit par,
                                         input bit stp, input bit dv,
                                         input bit bsy);
        logic [4:0] e5;
        logic [3:0] b4;
        e5 = 5'(e);
        b4 = 4'(b);
        return {e5, b4, dat, strt, deser, par, stp, dv, bsy};
    endfunction

    function automatic logic [15:0] out_vec();
        return {edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en,
                par_chk_en, stp_chk_en, data_valid, busy};
    endfunction

    // Expected outputs at cycle c of a frame (c = 0 is the detect cycle).
    function automatic logic [15:0] model_cycle(input int c, input int p,
                                                input bit pe, input bit ev);
        int len;
        int u;
        int e;
        len = (2 + DW + (pe ? 1 : 0)) * p;
        if (c == 0) return 16'h0000;
        if (c == len) return pack(0, 0, 0, 0, 0, 0, 0, ev, 1);
        u = c / p;
        e = c % p;
        if (u == 0) return pack(e, 0, 1, 1, 0, 0, 0, 0, 1);
        if (u <= DW) return pack(e, u - 1, 1, 0, (e == p / 2 + 1), 0, 0, 0, 1);
        if (pe && u == DW + 1) return pack(e, 0, 1, 0, 0, 1, 0, 0, 1);
        return pack(e, 0, 1, 0, 0, 0, 1, 0, 1);
    endfunction

    // Line level at cycle c: start bit, data LSB first, parity, stop.
    function automatic logic rx_level(input int c, input int p, input bit pe,
                                      input logic [7:0] d);
        int u;
        u = c / p;
        if (u == 0) return 1'b0;
        if (u <= DW) return d[u - 1];
        if (pe && u == DW + 1) return ^d;
        return 1'b1;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one full frame from the table and checks every cycle.
    task automatic apply_stimulus(input frame_vec_t v);
        int p;
        int len;
        int stop_start;
        int deser_seen;
        int dv_seen;
        p          = v.presc;
        len        = (2 + DW + (v.par_en ? 1 : 0)) * p;
        stop_start = (1 + DW + (v.par_en ? 1 : 0)) * p;
        deser_seen = 0;
        dv_seen    = 0;
        PAR_EN     = v.par_en;
        if (!v.chain_in) begin
            @(negedge clk);
            RX_IN    = 1'b0;
            Prescale = 6'(p);
            par_err  = v.par_err_f;
            stp_err  = 1'b0;
            #1;
            check_output({v.name, " detect"}, 32'(out_vec()), 32'h0);
        end
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            if (c == len) RX_IN = v.chain_out ? 1'b0 : 1'b1;
            else          RX_IN = rx_level(c, p, v.par_en, v.data);
            if (v.chg_presc != 0 && c == 20) Prescale = 6'(v.chg_presc);
            par_err = v.par_err_f;
            stp_err = v.stp_err_f && (c >= stop_start + p / 2 + 1);
            #1;
            check_output($sformatf("%s c%0d", v.name, c), 32'(out_vec()),
                         32'(model_cycle(c, p, v.par_en, v.exp_valid)));
            if (deser_en)   deser_seen++;
            if (data_valid) dv_seen++;
        end
        check_output({v.name, " deser_count"}, 32'(deser_seen), 32'(DW));
        check_output({v.name, " valid_count"}, 32'(dv_seen), 32'(v.exp_valid));
        if (!v.chain_out) begin
            @(negedge clk);
            par_err = 1'b0;
            stp_err = 1'b0;
            #1;
            check_output({v.name, " idle_after"}, 32'(out_vec()), 32'h0);
        end
    endtask

    initial begin
        //          name        presc par  data  perr serr chg cin cout valid
        vecs[0] = '{"p8_a5",       8, 1'b0, 8'hA5, 1'b0, 1'b0,  0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{"p16_parerr", 16, 1'b1, 8'h3C, 1'b1, 1'b0,  0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{"p32_stperr", 32, 1'b0, 8'h5A, 1'b0, 1'b1,  0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{"b2b_first",   8, 1'b0, 8'h12, 1'b0, 1'b0,  0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{"b2b_second",  8, 1'b0, 8'hED, 1'b0, 1'b0,  0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{"presc_chg",   8, 1'b0, 8'h0F, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{"p16_next",   16, 1'b0, 8'h81, 1'b0, 1'b0,  0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{"p16_par_ok", 16, 1'b1, 8'h77, 1'b0, 1'b0,  0, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{"p8_botherr",  8, 1'b1, 8'h00, 1'b1, 1'b1,  0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{"p8_perr_nop", 8, 1'b0, 8'hC3, 1'b1, 1'b0,  0, 1'b0, 1'b0, 1'b1};

        ARST_n      = 1'b0;
        RX_IN       = 1'b0;
        PAR_EN      = 1'b0;
        Prescale    = 6'd8;
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        #1;
        check_output("reset_outputs", 32'(out_vec()), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_held_rx_low", 32'(out_vec()), 32'h0);
        @(negedge clk);
        RX_IN  = 1'b1;
        ARST_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_output("idle_after_reset", 32'(out_vec()), 32'h0);

        for (int i = 0; i < 3; i++) apply_stimulus(vecs[i]);

        // Short start pulse rejected by the start checker at the last edge.
        begin
            int extra_act;
            @(negedge clk);
            RX_IN       = 1'b0;
            Prescale    = 6'd8;
            strt_glitch = 1'b0;
            #1;
            check_output("glitch detect", 32'(out_vec()), 32'h0);
            for (int c = 1; c <= 7; c++) begin
                @(negedge clk);
                RX_IN       = (c < 3) ? 1'b0 : 1'b1;
                strt_glitch = (c >= 6);
                #1;
                check_output($sformatf("glitch c%0d", c), 32'(out_vec()),
                             32'(model_cycle(c, 8, 1'b0, 1'b0)));
            end
            @(negedge clk);
            strt_glitch = 1'b0;
            #1;
            check_output("glitch back_idle", 32'(out_vec()), 32'h0);
            extra_act = 0;
            repeat (16) begin
                @(negedge clk);
                #1;
                if (busy || deser_en || data_valid) extra_act++;
            end
            check_output("glitch quiet_after", 32'(extra_act), 32'h0);
        end

        for (int i = 3; i < 10; i++) apply_stimulus(vecs[i]);

        // Reset pulsed in DATA while bit 3 is being received.
        begin
            int after_act;
            @(negedge clk);
            RX_IN    = 1'b0;
            Prescale = 6'd8;
            PAR_EN   = 1'b0;
            #1;
            check_output("rst detect", 32'(out_vec()), 32'h0);
            for (int c = 1; c <= 34; c++) begin
                @(negedge clk);
                RX_IN = rx_level(c, 8, 1'b0, 8'h3C);
                #1;
                check_output($sformatf("rst c%0d", c), 32'(out_vec()),
                             32'(model_cycle(c, 8, 1'b0, 1'b0)));
            end
            @(negedge clk);
            ARST_n = 1'b0;
            #1;
            check_output("rst midframe_async", 32'(out_vec()), 32'h0);
            @(negedge clk);
            RX_IN  = 1'b1;
            ARST_n = 1'b1;
            after_act = 0;
            repeat (100) begin
                @(negedge clk);
                #1;
                if (busy || data_valid || deser_en) after_act++;
            end
            check_output("rst no_resume", 32'(after_act), 32'h0);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
